// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480 timing defaults, lock FSM encoding and counter widths
package vga_timing_pkg;

    localparam int TOTAL_COL     = 800;
    localparam int TOTAL_ROW     = 525;
    localparam int ACTIVE_COL    = 640;
    localparam int ACTIVE_ROW    = 480;
    localparam int H_FRONT_PORCH = 16;
    localparam int V_FRONT_PORCH = 10;
    localparam int LOCK_LINES    = 8;

    localparam int COL_W    = 10;
    localparam int ROW_W    = 10;
    localparam int PERIOD_W = 11;
    localparam int LINE_W   = 10;
    localparam int GOOD_W   = 8;

    localparam logic [1:0] ST_UNLOCKED = 2'd0;
    localparam logic [1:0] ST_ACQUIRE  = 2'd1;
    localparam logic [1:0] ST_LOCKED   = 2'd2;

    typedef enum logic [1:0] {
        UNLOCKED = ST_UNLOCKED,
        ACQUIRE  = ST_ACQUIRE,
        LOCKED   = ST_LOCKED
    } lock_state_e;

endpackage

// File: rtl/vga_sync_to_count_if.sv
// rtl/vga_sync_to_count_if.sv - sync inputs and recovered timing outputs of the receiver
interface vga_sync_to_count_if;
    import vga_timing_pkg::*;

    logic             hsync;
    logic             vsync;
    logic [COL_W-1:0] col_counter;
    logic [ROW_W-1:0] row_counter;
    logic             active;
    logic             locked;
    logic             frame_start;

    modport master (
        output hsync, vsync,
        input  col_counter, row_counter, active, locked, frame_start
    );

    modport slave (
        input  hsync, vsync,
        output col_counter, row_counter, active, locked, frame_start
    );

endinterface

// File: rtl/vga_sync_edge.sv
// rtl/vga_sync_edge.sv - registers one sync input, normalises polarity, pulses on assertion
module vga_sync_edge #(
    parameter bit SYNC_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic edge_pulse
);

    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        sync_d = SYNC_LOW ? ~sync_in : sync_in;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign edge_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/vga_sync_to_count.sv
// rtl/vga_sync_to_count.sv - recovers col/row counters from HSync/VSync and qualifies lock
module vga_sync_to_count
    import vga_timing_pkg::*;
#(
    parameter int G_TOTAL_COL     = TOTAL_COL,
    parameter int G_TOTAL_ROW     = TOTAL_ROW,
    parameter int G_ACTIVE_COL    = ACTIVE_COL,
    parameter int G_ACTIVE_ROW    = ACTIVE_ROW,
    parameter int G_H_FRONT_PORCH = H_FRONT_PORCH,
    parameter int G_V_FRONT_PORCH = V_FRONT_PORCH,
    parameter bit G_SYNC_LOW      = 1'b1,
    parameter int G_LOCK_LINES    = LOCK_LINES
) (
    input logic                clk,
    input logic                rst,
    vga_sync_to_count_if.slave bus
);

    localparam logic [COL_W-1:0]    COL_LAST    = COL_W'(G_TOTAL_COL - 1);
    localparam logic [COL_W-1:0]    COL_ACT     = COL_W'(G_ACTIVE_COL);
    localparam logic [COL_W-1:0]    H_SS        = COL_W'(G_ACTIVE_COL + G_H_FRONT_PORCH);
    localparam logic [ROW_W-1:0]    ROW_LAST    = ROW_W'(G_TOTAL_ROW - 1);
    localparam logic [ROW_W-1:0]    ROW_ACT     = ROW_W'(G_ACTIVE_ROW);
    localparam logic [ROW_W-1:0]    V_SS        = ROW_W'(G_ACTIVE_ROW + G_V_FRONT_PORCH);
    localparam logic [PERIOD_W-1:0] PERIOD_GOOD = PERIOD_W'(G_TOTAL_COL);
    localparam logic [PERIOD_W-1:0] PERIOD_MAX  = PERIOD_W'(2 * G_TOTAL_COL);
    localparam logic [LINE_W-1:0]   LINES_GOOD  = LINE_W'(G_TOTAL_ROW);
    localparam logic [LINE_W-1:0]   LINE_MAX    = '1;
    localparam logic [GOOD_W-1:0]   GOOD_MIN    = GOOD_W'(G_LOCK_LINES);
    localparam logic [GOOD_W-1:0]   GOOD_MAX    = '1;

    logic h_edge, v_edge;

    vga_sync_edge #(.SYNC_LOW(G_SYNC_LOW)) u_h_edge (
        .clk(clk), .rst(rst), .sync_in(bus.hsync), .edge_pulse(h_edge)
    );

    vga_sync_edge #(.SYNC_LOW(G_SYNC_LOW)) u_v_edge (
        .clk(clk), .rst(rst), .sync_in(bus.vsync), .edge_pulse(v_edge)
    );

    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic                active_q, active_d;
    logic                frame_start_q, frame_start_d;
    logic [PERIOD_W-1:0] h_period_q, h_period_d;
    logic [LINE_W-1:0]   line_q, line_d, lines_seen;
    logic [GOOD_W-1:0]   good_q, good_d, good_after_h;
    logic [1:0]          state_q, state_d;
    logic                good_line, good_frame;

    always_comb begin
        // Sync edges snap the free-running counters onto the source's sync-start position
        col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
        row_d = row_q;
        if (h_edge) begin
            col_d = H_SS;
        end else if (col_q == COL_LAST) begin
            row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end
        if (v_edge) begin
            row_d = V_SS;
        end
        active_d      = (col_d < COL_ACT) && (row_d < ROW_ACT);
        frame_start_d = (col_d == '0) && (row_d == '0) && (state_q == ST_LOCKED);

        h_period_d = h_edge ? PERIOD_W'(1) :
                     (h_period_q == PERIOD_MAX) ? h_period_q : h_period_q + 1'b1;
        good_line  = h_edge && (h_period_q == PERIOD_GOOD);

        // A coincident H edge still belongs to the frame this V edge closes
        lines_seen = (h_edge && (line_q != LINE_MAX)) ? line_q + 1'b1 : line_q;
        good_frame = (lines_seen == LINES_GOOD);
        line_d     = v_edge ? '0 : lines_seen;

        good_after_h = good_q;
        if (h_edge) begin
            good_after_h = !good_line ? '0 :
                           (good_q == GOOD_MAX) ? good_q : good_q + 1'b1;
        end

        state_d = state_q;
        good_d  = good_q;
        case (state_q)
            ST_UNLOCKED: begin
                if (v_edge) begin
                    state_d = ST_ACQUIRE;
                    good_d  = '0;
                end
            end
            ST_ACQUIRE: begin
                good_d = good_after_h;
                if (v_edge) begin
                    good_d = '0;
                    if (good_frame && (good_after_h >= GOOD_MIN)) begin
                        state_d = ST_LOCKED;
                    end
                end
            end
            ST_LOCKED: begin
                if ((h_edge && !good_line) || (v_edge && !good_frame) ||
                    (h_period_q == PERIOD_MAX)) begin
                    state_d = ST_UNLOCKED;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q         <= '0;
            row_q         <= '0;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
            h_period_q    <= '0;
            line_q        <= '0;
            good_q        <= '0;
            state_q       <= ST_UNLOCKED;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
            h_period_q    <= h_period_d;
            line_q        <= line_d;
            good_q        <= good_d;
            state_q       <= state_d;
        end
    end

    assign bus.col_counter = col_q;
    assign bus.row_counter = row_q;
    assign bus.active      = active_q;
    assign bus.frame_start = frame_start_q;
    assign bus.locked      = (state_q == ST_LOCKED);

endmodule
